// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the programmable timer (timer_prog) and its
// prescaler. It holds the FSM state encodings, the counting-direction
// encodings and the enumerated state type built from those encodings.
// ---------------------------------------------------------------------------
package timer_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Counting direction, latched from t_mode at start
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Divides clk into count steps. The counter runs 0..DIV-1 while run is high
// and wraps to 0 at DIV-1. tick is asserted combinationally in the cycle the
// counter sits at DIV-1 with run high, so the owner acts on the wrap edge.
// The count is held while run is low, which preserves phase across a pause.
//
// Parameters:
//   DIV   clk cycles per tick (>= 1); DIV = 1 ticks on every run cycle.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active low
//   run   in   advance the counter this cycle
//   clr   in   synchronous clear of the counter (wins over run)
//   tick  out  high in the cycle the counter wraps
// ---------------------------------------------------------------------------
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    // A 1-bit counter is kept even for DIV = 1 so the vector is never empty.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = run & w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_last ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/timer_prog.sv
// ---------------------------------------------------------------------------
// timer_prog
// Programmable up/down timer with prescaler, single-button start/pause/
// resume, terminal-count stop and synchronous clear. The consumer samples
// t_out in the cycle t_valid pulses.
//
// Optional feature (macro TIMER_LAP_EN): adds t_lap_req / t_lap, a lap
// register that captures the count visible in a RUN or PAUSE cycle.
//
// Parameters:
//   WIDTH  width of t_out, t_load and t_lap (arithmetic modulo 2^WIDTH)
//   DIV    clk cycles per count step (>= 1)
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   t_en       in   start/pause/resume button, rising edge acted on
//   t_clr      in   synchronous clear, active high
//   t_mode     in   0 = up, 1 = down (sampled at start)
//   t_load     in   up: terminal value (0 = free run); down: start value
//   t_lap_req  in   capture request (TIMER_LAP_EN only)
//   t_lap      out  captured count (TIMER_LAP_EN only)
//   t_tick     out  one-cycle pulse per prescaler wrap while running
//   t_valid    out  one-cycle pulse, t_out holds a freshly stepped value
//   t_done     out  level, high in DONE
//   t_out      out  current count
// ---------------------------------------------------------------------------
module timer_prog
    import timer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_en,
    input  logic             t_clr,
    input  logic             t_mode,
    input  logic [WIDTH-1:0] t_load,
`ifdef TIMER_LAP_EN
    input  logic             t_lap_req,
    output logic [WIDTH-1:0] t_lap,
`endif
    output logic             t_tick,
    output logic             t_valid,
    output logic             t_done,
    output logic [WIDTH-1:0] t_out
);

    state_t           r_state;
    logic             r_en_q;
    logic             r_mode;
    logic [WIDTH-1:0] r_load;

    logic             w_ev;
    logic             w_start;
    logic             w_run;
    logic             w_presc_clr;
    logic             w_tick;
    logic [WIDTH-1:0] w_step;
    logic             w_hit;

    // Next count value in the latched direction (wraps modulo 2^WIDTH)
    function automatic logic [WIDTH-1:0] f_step(input logic mode,
                                                input logic [WIDTH-1:0] val);
        return (mode == MODE_DOWN) ? val - WIDTH'(1) : val + WIDTH'(1);
    endfunction

    assign w_ev    = t_en & ~r_en_q;
    assign w_start = w_ev & ((r_state == S_IDLE) | (r_state == S_DONE));

    // Pause wins over a tick landing in the same cycle: the prescaler is
    // frozen whenever a button edge or clear arrives, so no step is lost
    // or double-counted and the phase is kept for resume.
    assign w_run       = (r_state == S_RUN) & ~w_ev & ~t_clr;
    assign w_presc_clr = t_clr | w_start;

    assign w_step = f_step(r_mode, t_out);
    // Up with load 0 free-runs through the wrap; any other terminal is a stop.
    assign w_hit  = (r_mode == MODE_DOWN) ? (w_step == '0)
                                          : ((r_load != '0) && (w_step == r_load));

    timer_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .clr  (w_presc_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_en_q  <= 1'b0;
            r_mode  <= MODE_UP;
            r_load  <= '0;
            t_tick  <= 1'b0;
            t_valid <= 1'b0;
            t_done  <= 1'b0;
            t_out   <= '0;
        end else begin
            r_en_q  <= t_en;
            t_tick  <= 1'b0;
            t_valid <= 1'b0;
            if (t_clr) begin
                // Clear beats any button edge in the same cycle.
                r_state <= S_IDLE;
                t_out   <= '0;
                t_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (w_ev) begin
                            r_mode <= t_mode;
                            r_load <= t_load;
                            t_done <= 1'b0;
                            if (t_mode == MODE_DOWN) begin
                                t_out <= t_load;
                                // Counting down from 0 has nothing to do.
                                if (t_load == '0) begin
                                    r_state <= S_DONE;
                                    t_done  <= 1'b1;
                                end else begin
                                    r_state <= S_RUN;
                                end
                            end else begin
                                t_out   <= '0;
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_ev) begin
                            r_state <= S_PAUSE;
                        end else if (w_tick) begin
                            t_tick  <= 1'b1;
                            t_valid <= 1'b1;
                            t_out   <= w_step;
                            if (w_hit) begin
                                r_state <= S_DONE;
                                t_done  <= 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (w_ev) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef TIMER_LAP_EN
    logic [WIDTH-1:0] r_lap;

    // Captures the pre-step count visible in the request cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lap <= '0;
        end else if (t_clr) begin
            r_lap <= '0;
        end else if (t_lap_req && ((r_state == S_RUN) || (r_state == S_PAUSE))) begin
            r_lap <= t_out;
        end
    end

    assign t_lap = r_lap;
`else
    // Lap capture not built: no lap register and no lap ports.
`endif

endmodule
